imem_loader: RTL
================

Name: imem_loader

Overview:
- Upstream stage of the single-cycle MIPS CPU: receives a program as a byte stream over a valid/ready handshake.
- Packs bytes big-endian into 32-bit words and writes them sequentially into instruction memory from byte address 0.
- Holds the CPU (cpu_run=0) until the final word is committed, then releases it.

Parameters:
- ADDR_W, 6, word-address bits of instruction memory (capacity 2^ADDR_W words).
- MAX_WORDS, 64, maximum program length in words; must be <= 2^ADDR_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new load
- in_valid  input  1  in_byte is valid
- in_byte  input  8  program byte
- in_last  input  1  qualifies in_byte as the final byte of the program
- in_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write enable
- imem_a  output  32  instruction-memory byte address, word aligned
- imem_wd  output  32  instruction-memory write data
- cpu_run  output  1  CPU enable; gates the PC update
- word_count  output  ADDR_W+1  number of words committed
- err_overflow  output  1  program exceeded MAX_WORDS

Behaviour:
- A byte transfers when in_valid and in_ready are both high at a rising clk edge.
- States: IDLE, LOAD, COMMIT, RUN, ERROR.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all outputs 0; byte index 0; word buffer 0; word_count 0.
  - A reset during LOAD or COMMIT discards the partial word; no imem write occurs after reset asserts.
- IDLE: in_ready=0. start moves to LOAD.
- LOAD: in_ready=1.
  - Byte index b (0..3) places in_byte at bits [31-8b:24-8b]; b=0 is the MSB.
  - After byte 3 is accepted, or after any byte with in_last=1, move to COMMIT.
  - On in_last, unfilled low bytes are zero-padded.
- COMMIT (exactly 1 cycle): in_ready=0; imem_we=1; imem_a=word_count*4; imem_wd=packed word.
  - Next edge: word_count+1, byte index 0, buffer cleared.
  - If the committed word carried in_last, go to RUN; otherwise return to LOAD.
- Throughput: at most 4 bytes per 5 cycles.
- Overflow: accepting byte 0 when word_count==MAX_WORDS goes to ERROR instead of buffering the byte.
  - ERROR sets err_overflow=1, in_ready=0, cpu_run=0; no write is performed.
- RUN: cpu_run=1; in_ready=0; imem_we=0.
- start while in RUN or ERROR:
  - returns to LOAD and clears word_count, err_overflow and cpu_run in the same edge;
  - previously written imem contents are not erased.
- start while in LOAD or COMMIT is ignored.
- Bytes presented while in_ready=0 are not consumed; the source holds them.
- imem_a upper bits above ADDR_W+2 are always 0. imem_a and imem_wd are 0 whenever imem_we=0.
- cpu_run is registered. The CPU's first fetch (PC=0) happens on the edge after cpu_run rises.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], the XOR of every committed word. It updates on the COMMIT edge and clears on reset and on start.
  - Adds input expected_sum[31:0], sampled on the edge that enters RUN.
  - On mismatch, go to ERROR with err_overflow=0 and additional output err_checksum=1 (also defined only with the macro).
- Undefined: no checksum logic or ports; entering RUN is unconditional.

Test Plan:
- Reset, start, then bytes 20 08 00 05 / 20 09 00 07 (last on final byte):
  - writes 0x20080005 @0 and 0x20090007 @4;
  - word_count=2; cpu_run=1 one cycle after the second COMMIT.
- 6-byte program AA BB CC DD 11 22(last) -> second write is 0x11220000 @4; cpu_run=1.
- MAX_WORDS=2, 9 bytes sent -> two writes; the 9th byte drives ERROR; err_overflow=1; cpu_run=0; no third imem_we.
- Assert reset after 2 bytes of word 1:
  - all outputs 0 immediately, no write;
  - a fresh start plus 4 bytes writes to address 0.
- in_valid toggled 1/0 every cycle with bytes 01 02 03 04(last) -> single write 0x01020304 @0; in_ready=0 during COMMIT; no byte lost.
- With IMEM_LOADER_CHECKSUM_EN:
  - program 0x00000001, 0x00000003 and expected_sum=0x00000002 -> RUN;
  - same program with expected_sum=0x00000005 -> ERROR, err_checksum=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream over a valid/ready handshake
// and packs the bytes big-endian into 32-bit words. The words are written one
// after another into instruction memory, starting at byte address 0. The CPU
// is held (cpu_run=0) until the final word has been committed.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds expected_sum,
// checksum and err_checksum; a checksum mismatch at end of load -> ERROR).
//
// Handshake: a byte transfers on a rising clk edge when in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid. A source that
// presents a byte while in_ready=0 must hold it until it is accepted.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           one-cycle pulse; begins a new load (from IDLE/RUN/ERROR)
//   in_valid/in_byte/in_last/in_ready   byte stream; in_last marks final byte
//   imem_we/imem_a/imem_wd              instruction-memory write port
//   cpu_run         registered CPU enable
//   word_count      words committed in the current load
//   err_overflow    program exceeded MAX_WORDS
//   dbg_state       current FSM state, for observation
module imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [31:0]       expected_sum,
  output logic [31:0]       checksum,
  output logic              err_checksum,
`endif
  output logic              in_ready,
  output logic              imem_we,
  output logic [31:0]       imem_a,
  output logic [31:0]       imem_wd,
  output logic              cpu_run,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic        last_seen;   // the word being assembled carries in_last

  // Outputs decoded from state, so an asynchronous reset silences the write
  // port in the same instant it is asserted.
  assign in_ready  = (state == S_LOAD);
  assign imem_we   = (state == S_COMMIT);
  assign imem_wd   = imem_we ? word_buf : 32'd0;
  assign imem_a    = imem_we ? {{(30 - ADDR_W){1'b0}}, word_count[ADDR_W-1:0], 2'b00}
                             : 32'd0;
  assign dbg_state = state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic sum_ok;
  // Sum including the word being committed, compared on the edge entering RUN.
  assign sum_ok = ((checksum ^ word_buf) == expected_sum);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_idx     <= 2'd0;
      word_buf     <= 32'd0;
      last_seen    <= 1'b0;
      word_count   <= '0;
      cpu_run      <= 1'b0;
      err_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum     <= 32'd0;
      err_checksum <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state        <= S_LOAD;
            byte_idx     <= 2'd0;
            word_buf     <= 32'd0;
            last_seen    <= 1'b0;
            word_count   <= '0;
            cpu_run      <= 1'b0;
            err_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum     <= 32'd0;
            err_checksum <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (byte_idx == 2'd0 && word_count == MAX_CNT) begin
              // A new word would not fit: drop the byte and flag overflow.
              state        <= S_ERROR;
              err_overflow <= 1'b1;
            end else begin
              // Byte b lands at bits [31-8b:24-8b]; low bytes stay zero.
              word_buf  <= word_buf | ({in_byte, 24'd0} >> {byte_idx, 3'b000});
              byte_idx  <= byte_idx + 2'd1;
              last_seen <= in_last;
              if (byte_idx == 2'd3 || in_last) state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          word_count <= word_count + 1'b1;
          byte_idx   <= 2'd0;
          word_buf   <= 32'd0;
          last_seen  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum   <= checksum ^ word_buf;
          if (last_seen) begin
            if (sum_ok) begin
              state   <= S_RUN;
              cpu_run <= 1'b1;
            end else begin
              state        <= S_ERROR;
              err_checksum <= 1'b1;
            end
          end else begin
            state <= S_LOAD;
          end
`else
          if (last_seen) begin
            state   <= S_RUN;
            cpu_run <= 1'b1;
          end else begin
            state <= S_LOAD;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
